resp_misr_compactor: RTL and testbench

//   Downstream response compactor for the merged sequential/combinational pattern netlists.

---
 rtl/resp_misr_compactor.sv | 101 ++++++++++
 tb/tb_resp_misr_compactor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_compactor.sv
// Response compactor: registers the pattern-netlist outputs and folds them into a MISR
// over a programmed window of cycles, then holds the signature until it is acknowledged.
module resp_misr_compactor #(
    parameter int unsigned             RESP_W = 11,
    parameter int unsigned             SIG_W  = 16,
    parameter logic [SIG_W-1:0]        POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]        SEED   = '0,
    parameter int unsigned             WINDOW = 64
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic [RESP_W-1:0] resp_in,
    input  logic              start,
    input  logic              abort,
    input  logic              sig_ack,
    output logic [SIG_W-1:0]  sig_out,
    output logic              sig_valid,
    output logic              busy,
    output logic [7:0]        win_cnt
);

    localparam int unsigned     CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RESP_W-1:0] resp_q;
    logic [SIG_W-1:0]  misr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        win_q;
    logic              misr_load, misr_step, win_inc;

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                  input logic [RESP_W-1:0] r);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ SIG_W'(r);
    endfunction

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) state_q <= ST_IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        misr_load = 1'b0;
        misr_step = 1'b0;
        win_inc   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_RUN;
                misr_load = 1'b1;
            end
            ST_RUN: begin
                misr_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    win_inc = 1'b1;
                end
            end
            ST_DONE: if (sig_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort overrides every other action in the same cycle, including the final RUN step
        if (abort) begin
            state_d   = ST_IDLE;
            misr_load = 1'b0;
            misr_step = 1'b0;
            win_inc   = 1'b0;
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            resp_q <= '0;
            misr_q <= SEED;
            cnt_q  <= '0;
            win_q  <= '0;
        end else begin
            resp_q <= resp_in;
            if (misr_load) begin
                misr_q <= SEED;
                cnt_q  <= '0;
            end else if (misr_step) begin
                misr_q <= misr_next(misr_q, resp_q);
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (win_inc) win_q <= win_q + 8'd1;
        end
    end

    assign sig_out   = misr_q;
    assign sig_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign win_cnt   = win_q;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Randomized bench for resp_misr_compactor: four instances with different windows, checked
// against a GF(2) polynomial-remainder model of the signature.
module tb_resp_misr_compactor;

    localparam int          NI   = 4;
    localparam int          WINS [NI] = '{1, 2, 17, 64};
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] resp_in;
    logic        start_v [NI];
    logic        abort_v [NI];
    logic        ack_v   [NI];
    logic [15:0] sig_out_v   [NI];
    logic        sig_valid_v [NI];
    logic        busy_v      [NI];
    logic [7:0]  win_cnt_v   [NI];

    int          n_vec = 0;
    int          n_bad = 0;
    int          exp_win [NI];
    logic [10:0] dq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        resp_misr_compactor #(
            .RESP_W (11),
            .SIG_W  (16),
            .POLY   (POLY),
            .SEED   (SEED),
            .WINDOW (WINS[g])
        ) u_dut (
            .blif_clk_net   (clk),
            .blif_reset_net (rst_n),
            .resp_in        (resp_in),
            .start          (start_v[g]),
            .abort          (abort_v[g]),
            .sig_ack        (ack_v[g]),
            .sig_out        (sig_out_v[g]),
            .sig_valid      (sig_valid_v[g]),
            .busy           (busy_v[g]),
            .win_cnt        (win_cnt_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // v * x^k mod P(x)
    function automatic logic [15:0] mulx(input logic [15:0] v, input int k);
        logic [15:0] a = v;
        for (int j = 0; j < k; j++) a = a[15] ? ((a << 1) ^ POLY) : (a << 1);
        return a;
    endfunction

    // Signature is linear: SEED*x^n + sum r_i*x^(n-1-i), reduced mod P
    function automatic logic [15:0] sig_ref(input int n);
        logic [15:0] acc = mulx(SEED, n);
        for (int j = 0; j < n; j++) acc ^= mulx({5'b0, dq[j]}, n - 1 - j);
        return acc;
    endfunction

    task automatic fill_rand(input int n);
        dq.delete();
        for (int j = 0; j < n; j++) dq.push_back(11'($urandom));
    endtask

    task automatic run_window(input int i, input bit do_ack);
        int          w = WINS[i];
        logic [15:0] exp_sig = sig_ref(w);
        for (int k = 0; k <= w + 1; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("valid_rise", 32'(sig_valid_v[i]), 32'(k == w + 1));
                check("busy_run", 32'(busy_v[i]), 32'd1);
            end
            resp_in    = (k < w) ? dq[k] : 11'($urandom);
            start_v[i] = (k == 0);
        end
        exp_win[i] = (exp_win[i] + 1) % 256;
        check("sig", 32'(sig_out_v[i]), 32'(exp_sig));
        check("win_cnt", 32'(win_cnt_v[i]), 32'(exp_win[i]));
        if (do_ack) begin
            ack_v[i] = 1'b1;
            @(negedge clk);
            ack_v[i] = 1'b0;
            check("ack_valid", 32'(sig_valid_v[i]), 32'd0);
            check("ack_busy", 32'(busy_v[i]), 32'd0);
            check("idle_hold", 32'(sig_out_v[i]), 32'(exp_sig));
        end
    endtask

    initial begin
        logic [15:0] pre_sig;
        logic [7:0]  pre_win;
        bit          rose;

        rst_n   = 1'b0;
        resp_in = '0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 0; abort_v[i] = 0; ack_v[i] = 0; exp_win[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_sig", 32'(sig_out_v[i]), 32'(SEED));
            check("rst_valid", 32'(sig_valid_v[i]), 32'd0);
            check("rst_busy", 32'(busy_v[i]), 32'd0);
            check("rst_win", 32'(win_cnt_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        dq.delete(); dq.push_back(11'h7FF);
        run_window(0, 1);
        check("t1_sig", 32'(sig_out_v[0]), 32'h07FF);

        dq.delete(); dq.push_back(11'h001); dq.push_back(11'h001);
        run_window(1, 1);
        check("t2_sig", 32'(sig_out_v[1]), 32'h0003);
        check("t2_win", 32'(win_cnt_v[1]), 32'd1);

        dq.delete(); dq.push_back(11'h001);
        for (int j = 1; j < 17; j++) dq.push_back(11'h000);
        run_window(2, 1);
        check("t3_sig", 32'(sig_out_v[2]), 32'h1021);

        for (int r = 0; r < 4; r++) begin
            fill_rand(64); run_window(3, 1);
            fill_rand(17); run_window(2, 1);
            fill_rand(2);  run_window(1, 1);
        end

        // DONE held without ack; start pulses must not disturb it
        fill_rand(17);
        run_window(2, 0);
        pre_sig = sig_out_v[2];
        for (int c = 0; c < 10; c++) begin
            start_v[2] = (c == 3 || c == 5);
            resp_in    = 11'($urandom);
            @(negedge clk);
            check("done_valid", 32'(sig_valid_v[2]), 32'd1);
            check("done_sig", 32'(sig_out_v[2]), 32'(pre_sig));
        end
        start_v[2] = 1'b1; ack_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0; ack_v[2] = 1'b0;
        check("ackstart_valid", 32'(sig_valid_v[2]), 32'd0);
        check("ackstart_busy", 32'(busy_v[2]), 32'd0);
        @(negedge clk);
        check("ackstart_idle", 32'(busy_v[2]), 32'd0);

        // abort mid-RUN
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v[3] = 1'b0;
        repeat (10) begin resp_in = 11'($urandom); @(negedge clk); end
        pre_sig = sig_out_v[3]; pre_win = win_cnt_v[3];
        abort_v[3] = 1'b1;
        @(negedge clk);
        abort_v[3] = 1'b0;
        check("abort_busy", 32'(busy_v[3]), 32'd0);
        check("abort_sig", 32'(sig_out_v[3]), 32'(pre_sig));
        check("abort_win", 32'(win_cnt_v[3]), 32'(pre_win));
        rose = 0;
        repeat (70) begin
            resp_in = 11'($urandom);
            @(negedge clk);
            if (sig_valid_v[3]) rose = 1;
        end
        check("abort_noval", 32'(rose), 32'd0);

        // abort coinciding with the final RUN cycle blocks DONE
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        pre_sig = sig_out_v[1]; pre_win = win_cnt_v[1];
        abort_v[1] = 1'b1;
        @(negedge clk);
        abort_v[1] = 1'b0;
        check("abortlast_busy", 32'(busy_v[1]), 32'd0);
        check("abortlast_valid", 32'(sig_valid_v[1]), 32'd0);
        check("abortlast_sig", 32'(sig_out_v[1]), 32'(pre_sig));
        check("abortlast_win", 32'(win_cnt_v[1]), 32'(pre_win));

        // abort beats start in IDLE
        pre_sig = sig_out_v[0];
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        check("abortstart_busy", 32'(busy_v[0]), 32'd0);
        check("abortstart_sig", 32'(sig_out_v[0]), 32'(pre_sig));

        // asynchronous reset mid-RUN
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v[3] = 1'b0;
        repeat (20) begin resp_in = 11'($urandom); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_v[3]), 32'd0);
        check("arst_sig", 32'(sig_out_v[3]), 32'(SEED));
        check("arst_win", 32'(win_cnt_v[3]), 32'd0);
        check("arst_win0", 32'(win_cnt_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) exp_win[i] = 0;
        @(negedge clk);
        check("arst_after", 32'(sig_valid_v[3]), 32'd0);

        // 256 back-to-back single-cycle windows
        for (int n = 0; n < 256; n++) begin
            fill_rand(1);
            run_window(0, 1);
            check("t6_sig", 32'(sig_out_v[0]), 32'({5'b0, dq[0]}));
        end
        check("t6_wrap", 32'(win_cnt_v[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
